farm_sensor_conditioner: RTL

FARM_SENSOR_CONDITIONER -- requirements
Module: farm_sensor_conditioner

---
 rtl/farm_sensor_conditioner.sv | 120 ++++++++++++
 1 files changed

// File: rtl/farm_sensor_conditioner.sv
// farm_sensor_conditioner
// Conditions the farm-road loop detector for the traffic-light controller.
// The raw detector is synchronized and then debounced. Each debounced 0->1
// flip counts as one vehicle arrival. The rising edge of the controller's
// "farm road yellow" phase marks those waiting vehicles as served.
//
// Build option: define SENSOR_QUEUE_COUNT_EN to keep a saturating queue
// count of waiting vehicles. When it is undefined, a single request flop
// replaces the counter.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples needed to flip (1..255)
//   MAX_QUEUE        saturation value of the queue count (1..15)
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   raw_sensor_i   in   loop detector, asynchronous to clk, may bounce
//   farm_served_i  in   high while the farm road is yellow (sync to clk)
//   sensor_o       out  high while at least one farm vehicle is waiting
//   debounced_o    out  synchronized, debounced detector level
//   vehicle_cnt_o  out  number of waiting farm vehicles
module farm_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_QUEUE       = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_sensor_i,
    input  logic       farm_served_i,
    output logic       sensor_o,
    output logic       debounced_o,
    output logic [3:0] vehicle_cnt_o
);

    localparam logic [7:0] LAST_SAMPLE = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] dbCnt;
    logic       servedQ;
    logic       differs;
    logic       flip;
    logic       arrival;
    logic       servedEvt;

    assign differs   = (sync2 != debounced_o);
    // The flip happens on the DEBOUNCE_CYCLES-th consecutive differing
    // sample. At that point the counter already holds DEBOUNCE_CYCLES-1.
    assign flip      = differs && (dbCnt == LAST_SAMPLE);
    assign arrival   = flip && sync2;
    assign servedEvt = farm_served_i && !servedQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            dbCnt       <= 8'd0;
            servedQ     <= 1'b0;
            debounced_o <= 1'b0;
        end else begin
            sync1   <= raw_sensor_i;
            sync2   <= sync1;
            servedQ <= farm_served_i;
            if (!differs) begin
                dbCnt <= 8'd0;
            end else if (flip) begin
                dbCnt       <= 8'd0;
                debounced_o <= sync2;
            end else begin
                dbCnt <= dbCnt + 8'd1;
            end
        end
    end

`ifdef SENSOR_QUEUE_COUNT_EN
    localparam logic [3:0] MAX_Q = 4'(MAX_QUEUE);

    logic [3:0] cntNext;

    // A served event clears the queue first. An arrival on the same edge
    // then adds itself, which leaves the count at 1.
    always_comb begin
        cntNext = vehicle_cnt_o;
        if (servedEvt) begin
            cntNext = arrival ? 4'd1 : 4'd0;
        end else if (arrival && (vehicle_cnt_o != MAX_Q)) begin
            cntNext = vehicle_cnt_o + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vehicle_cnt_o <= 4'd0;
            sensor_o      <= 1'b0;
        end else begin
            vehicle_cnt_o <= cntNext;
            sensor_o      <= (cntNext != 4'd0);
        end
    end
`else
    logic request;

    // Arrival wins over a coincident served event, so that vehicle stays
    // requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            request <= 1'b0;
        end else if (arrival) begin
            request <= 1'b1;
        end else if (servedEvt) begin
            request <= 1'b0;
        end
    end

    assign sensor_o      = request;
    assign vehicle_cnt_o = {3'b000, request};
`endif

endmodule
